// File: rtl/npc_pkg.sv
// Shared fetch-front-end definitions: FSM state encoding and fetch constants.
package npc_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_KILL = 2'd2,
    ST_HOLD = 2'd3
  } fetchState_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam int          INST_BYTES   = 4;

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch front end: owns the PC, keeps one imem read in flight and
// hands {pc, inst, fault} to decode over valid/ready, honouring exu redirects.
module ifu_fetch
  import npc_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEF)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  input  logic                  imem_rsp_err,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic [DATA_WIDTH-1:0] if_inst,
  output logic                  if_fault
);

  fetchState_e           state, stateNext;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  misal, reqFire, ifFire;
  logic                  latchRsp, latchMisal;

  assign misal          = pc[1:0] != 2'b00;
  assign imem_req_valid = !rst && (state == ST_REQ) && !misal;
  assign imem_req_addr  = pc;
  assign if_valid       = !rst && (state == ST_HOLD) && !redirect_valid;
  assign reqFire        = imem_req_valid && imem_req_ready;
  assign ifFire         = if_valid && if_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_REQ;
    else     state <= stateNext;
  end

  // Redirect outranks every other event in every state.
  always_comb begin
    stateNext  = state;
    latchRsp   = 1'b0;
    latchMisal = 1'b0;
    case (state)
      ST_REQ: begin
        if (redirect_valid) stateNext = reqFire ? ST_KILL : ST_REQ;
        else if (misal) begin
          latchMisal = 1'b1;
          stateNext  = ST_HOLD;
        end else if (reqFire) stateNext = ST_WAIT;
      end
      ST_WAIT: begin
        if (redirect_valid) stateNext = imem_rsp_valid ? ST_REQ : ST_KILL;
        else if (imem_rsp_valid) begin
          latchRsp  = 1'b1;
          stateNext = ST_HOLD;
        end
      end
      ST_KILL: if (imem_rsp_valid) stateNext = ST_REQ;
      ST_HOLD: if (redirect_valid || ifFire) stateNext = ST_REQ;
      default: stateNext = ST_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      if_pc    <= '0;
      if_inst  <= '0;
      if_fault <= 1'b0;
    end else begin
      if (redirect_valid)                 pc <= redirect_pc;
      else if (state == ST_HOLD && ifFire) pc <= pc + ADDR_WIDTH'(INST_BYTES);
      if (latchRsp) begin
        if_pc    <= pc;
        if_inst  <= imem_rsp_err ? '0 : imem_rsp_data;
        if_fault <= imem_rsp_err;
      end else if (latchMisal) begin
        if_pc    <= pc;
        if_inst  <= '0;
        if_fault <= 1'b1;
      end
    end
  end

  // Memory must only answer while a request is outstanding.
  rspOnlyWhenPending: assert property (@(posedge clk) disable iff (rst)
    !(imem_rsp_valid && (state == ST_REQ || state == ST_HOLD)));

endmodule
